// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 multicycle core:
// opcodes, funct codes, FSM states, ALU ops, immediate formats.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] ir,
    input imm_fmt_e    f
  );
    case (f)
      IMM_I: imm_gen = {{20{ir[31]}}, ir[31:20]};
      IMM_S: imm_gen = {{20{ir[31]}}, ir[31:25],
                        ir[11:7]};
      IMM_B: imm_gen = {{19{ir[31]}}, ir[31], ir[7],
                        ir[30:25], ir[11:8], 1'b0};
      IMM_U: imm_gen = {ir[31:12], 12'b0};
      IMM_J: imm_gen = {{11{ir[31]}}, ir[31],
                        ir[19:12], ir[20],
                        ir[30:21], 1'b0};
      default: imm_gen = '0;
    endcase
  endfunction

  // alt selects SUB for ADD and SRA for SR
  function automatic alu_op_e alu_sel(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      F3_ADD:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_sel = ALU_SLL;
      F3_SLT:  alu_sel = ALU_SLT;
      F3_SLTU: alu_sel = ALU_SLTU;
      F3_XOR:  alu_sel = ALU_XOR;
      F3_SR:   alu_sel = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_multicycle_core_if.sv
// Memory port bundle: req/ready handshake, address, data.
// master: req, we, addr, wdata out; rdata, ready in.
interface rv32_multicycle_core_if #(
  parameter int AW = 10
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/rv32_multicycle_core_alu.sv
// Combinational RV32I ALU with branch compare flags.
// in: op, a, b; out: y, eq, lt (signed), ltu.
module rv32_alu
  import rv32_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  always_comb begin
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    y   = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'b0, lt};
      ALU_SLTU:   y = {31'b0, ltu};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I core: BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT.
// Ports: CLK, RSTn, imem/dmem (master), halted, illegal.
module rv32_multicycle_core
  import rv32_pkg::*;
#(
  parameter int          IMEM_AW  = 10,
  parameter int          DMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic CLK,
  input  logic RSTn,
  rv32_multicycle_core_if.master imem,
  rv32_multicycle_core_if.master dmem,
  output logic halted,
  output logic illegal
);

  state_e             state;
  logic [31:0]        pc, npc, ir;
  logic [31:0]        opa, opb, imm, res;
  logic [DMEM_AW-1:0] addr;
  logic [31:0]        rf [1:31];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;
  logic is_sys;

  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BRANCH);
  assign is_ld    = (opc == OPC_LOAD);
  assign is_st    = (opc == OPC_STORE);
  assign is_opi   = (opc == OPC_OPIMM);
  assign is_op    = (opc == OPC_OP);
  assign is_sys   = (opc == OPC_SYSTEM);

  imm_fmt_e fmt;
  logic     legal;

  always_comb begin
    fmt   = IMM_I;
    legal = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc: begin
        fmt   = IMM_U;
        legal = 1'b1;
      end
      is_jal: begin
        fmt   = IMM_J;
        legal = 1'b1;
      end
      is_jalr: legal = (f3 == F3_ADD);
      is_br: begin
        fmt   = IMM_B;
        legal = (f3[2:1] != 2'b01);
      end
      is_ld: legal = (f3 == F3_W);
      is_st: begin
        fmt   = IMM_S;
        legal = (f3 == F3_W);
      end
      is_opi: begin
        if (f3 == F3_SLL)
          legal = (f7 == F7_BASE);
        else if (f3 == F3_SR)
          legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else
          legal = 1'b1;
      end
      is_op: begin
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) &&
                 ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      default: legal = 1'b0;
    endcase
  end

  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        eq, lt, ltu;

  always_comb begin
    alu_a  = opa;
    alu_b  = imm;
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_op: begin
        alu_b  = opb;
        alu_op = alu_sel(f3, f7[5]);
      end
      // imm bit 30 only means SRAI for shifts
      is_opi:   alu_op = alu_sel(f3, f7[5] && (f3 == F3_SR));
      is_lui:   alu_op = ALU_PASS_B;
      is_auipc: alu_a  = pc;
      is_br:    alu_b  = opb;
      default:  alu_op = ALU_ADD;
    endcase
  end

  rv32_alu u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  logic taken;

  always_comb begin
    case (f3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] pc4, pc_imm;

  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  function automatic logic [31:0] rf_rd(
    input logic [4:0] r
  );
    rf_rd = (r == 5'd0) ? 32'h0 : rf[r];
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      npc     <= '0;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      imm     <= '0;
      res     <= '0;
      addr    <= '0;
      illegal <= 1'b0;
      for (int i = 1; i < 32; i++)
        rf[i] <= '0;
    end else begin
      unique case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          if (imem.ready) begin
            ir    <= imem.rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa <= rf_rd(rs1);
          opb <= rf_rd(rs2);
          imm <= imm_gen(ir, fmt);
          if (is_sys) begin
            state <= S_HALT;
          end else if (!legal) begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res  <= alu_y;
          npc  <= pc4;
          addr <= alu_y[DMEM_AW+1:2];
          unique case (1'b1)
            is_br: begin
              if (!taken) begin
                pc    <= pc4;
                state <= S_FETCH;
              end else if (pc_imm[1]) begin
                illegal <= 1'b1;
                state   <= S_HALT;
              end else begin
                pc    <= pc_imm;
                state <= S_FETCH;
              end
            end
            // target checked in WB so rd still gets the link
            is_jal: begin
              res   <= pc4;
              npc   <= pc_imm;
              state <= S_WB;
            end
            is_jalr: begin
              res   <= pc4;
              npc   <= alu_y & ~32'h1;
              state <= S_WB;
            end
            is_ld, is_st: begin
              if (alu_y[1:0] != 2'b00) begin
                illegal <= 1'b1;
                state   <= S_HALT;
              end else begin
                state <= S_MEM;
              end
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem.ready) begin
            if (is_st) begin
              pc    <= pc4;
              state <= S_FETCH;
            end else begin
              res   <= dmem.rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0)
            rf[rd] <= res;
          if (npc[1]) begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            pc    <= npc;
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  assign halted = (state == S_HALT);

  assign imem.req   = (state == S_FETCH);
  assign imem.we    = 1'b0;
  assign imem.wdata = '0;
  assign imem.addr  = imem.req ? pc[IMEM_AW+1:2] : '0;

  assign dmem.req   = (state == S_MEM);
  assign dmem.we    = dmem.req && is_st;
  assign dmem.addr  = dmem.req ? addr : '0;
  assign dmem.wdata = dmem.req ? opb : '0;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core with
// wait-state memory models and hand-computed expectations.
module tb_rv32_multicycle_core;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic halted, illegal;

  always #5 CLK = ~CLK;

  rv32_multicycle_core_if #(.AW(10)) imem ();
  rv32_multicycle_core_if #(.AW(10)) dmem ();

  rv32_multicycle_core #(
    .IMEM_AW  (10),
    .DMEM_AW  (10),
    .RESET_PC (32'h0)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .imem    (imem),
    .dmem    (dmem),
    .halted  (halted),
    .illegal (illegal)
  );

  logic [31:0] imem_mem [1024];
  logic [31:0] dmem_mem [1024];
  int dwait = 0;
  int dcnt  = 0;
  int cyc   = 0;

  assign imem.ready = imem.req;
  assign imem.rdata = imem_mem[imem.addr];
  assign dmem.ready = dmem.req && (dcnt >= dwait);
  assign dmem.rdata = dmem_mem[dmem.addr];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (dmem.req && !dmem.ready) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (dmem.req && dmem.we && dmem.ready)
      dmem_mem[dmem.addr] <= dmem.wdata;
  end

  int       nf, n_dreq, n_sreq, n_lreq, sbad;
  int       ft [64];
  logic [9:0] fa [64];

  always @(negedge CLK) begin
    if (!RSTn) begin
      nf = 0; n_dreq = 0; n_sreq = 0;
      n_lreq = 0; sbad = 0;
    end else begin
      if (imem.req && imem.ready && nf < 64) begin
        ft[nf] = cyc;
        fa[nf] = imem.addr;
        nf++;
      end
      if (dmem.req) begin
        n_dreq++;
        if (dmem.we) begin
          n_sreq++;
          if (dmem.addr != 10'd4 ||
              dmem.wdata != 32'hFFFF_FFFE)
            sbad++;
        end else begin
          n_lreq++;
        end
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  localparam logic [31:0] MAIN [18] = '{
    32'h00500093, 32'hFF908113, 32'h00202823,
    32'h01002183, 32'h00114463, 32'h00100213,
    32'h00116463, 32'h80000437, 32'h40445493,
    32'h40208533, 32'h0020B5B3, 32'h0020A633,
    32'h00001697, 32'h00F14713, 32'h008007EF,
    32'h00200213, 32'h10000093, 32'h003082E7
  };
  localparam int LAT [15] = '{
    4, 4, 7, 8, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4
  };
  localparam int FADDR [16] = '{
    0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 16, 17
  };

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      imem_mem[i] = '0;
      dmem_mem[i] = '0;
    end
  endtask

  task automatic load_main();
    clear_mem();
    for (int i = 0; i < 18; i++) imem_mem[i] = MAIN[i];
  endtask

  task automatic hold_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // release at a negedge; that cycle is BOOT (cycle 1)
  task automatic release_check();
    int c;
    RSTn = 1'b1;
    c = 1;
    while (!imem.req && c < 10) begin
      @(posedge CLK); #1;
      c++;
    end
    check("first_fetch_cycle", c, 2);
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while (!halted && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    check("halt_reached", {31'b0, halted}, 1);
  endtask

  initial begin
    int n;
    load_main();
    dwait = 3;
    hold_reset();
    check("rst_imem_req", {31'b0, imem.req}, 0);
    check("rst_dmem_req", {31'b0, dmem.req}, 0);
    check("rst_imem_addr", {22'b0, imem.addr}, 0);
    check("rst_halted", {31'b0, halted}, 0);
    check("rst_illegal", {31'b0, illegal}, 0);
    check("rst_pc", dut.pc, 32'h0);
    release_check();
    run(600);
    check("main_illegal", {31'b0, illegal}, 1);
    check("main_pc", dut.pc, 32'h44);
    check("x1", dut.rf[1], 32'h100);
    check("x2", dut.rf[2], 32'hFFFF_FFFE);
    check("x3", dut.rf[3], 32'hFFFF_FFFE);
    check("x4_skipped", dut.rf[4], 32'h0);
    check("x5_link", dut.rf[5], 32'h48);
    check("x8_lui", dut.rf[8], 32'h8000_0000);
    check("x9_srai", dut.rf[9], 32'hF800_0000);
    check("x10_sub", dut.rf[10], 32'h7);
    check("x11_sltu", dut.rf[11], 32'h1);
    check("x12_slt", dut.rf[12], 32'h0);
    check("x13_auipc", dut.rf[13], 32'h1030);
    check("x14_xori", dut.rf[14], 32'hFFFF_FFF1);
    check("x15_jal", dut.rf[15], 32'h3C);
    check("dmem_word4", dmem_mem[4], 32'hFFFF_FFFE);
    check("sw_req_cycles", n_sreq, 4);
    check("sw_stable", sbad, 0);
    check("lw_req_cycles", n_lreq, 4);
    check("fetch_count", nf, 16);
    for (int i = 0; i < 15; i++)
      check($sformatf("lat%0d", i),
            ft[i+1] - ft[i], LAT[i]);
    for (int i = 0; i < 16; i++)
      check($sformatf("faddr%0d", i),
            {22'b0, fa[i]}, FADDR[i]);

    // misaligned load
    clear_mem();
    imem_mem[0] = 32'h01302183;
    dwait = 0;
    hold_reset();
    release_check();
    run(50);
    check("lw13_illegal", {31'b0, illegal}, 1);
    check("lw13_pc", dut.pc, 32'h0);
    check("lw13_no_dreq", n_dreq, 0);

    // ECALL
    clear_mem();
    imem_mem[0] = 32'h00000073;
    hold_reset();
    release_check();
    run(50);
    check("ecall_illegal", {31'b0, illegal}, 0);
    check("ecall_pc", dut.pc, 32'h0);

    // bad funct7 on SLL
    clear_mem();
    imem_mem[0] = 32'h00500093;
    imem_mem[1] = 32'h40209533;
    hold_reset();
    release_check();
    run(50);
    check("badf7_illegal", {31'b0, illegal}, 1);
    check("badf7_pc", dut.pc, 32'h4);
    check("badf7_x1", dut.rf[1], 32'h5);
    check("badf7_x10", dut.rf[10], 32'h0);

    // reset while a store waits
    load_main();
    dwait = 20;
    hold_reset();
    RSTn = 1'b1;
    n = 0;
    while (!dmem.req && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("saw_dmem_req", {31'b0, dmem.req}, 1);
    #2 RSTn = 1'b0;
    #1;
    check("async_dmem_req", {31'b0, dmem.req}, 0);
    check("async_imem_req", {31'b0, imem.req}, 0);
    check("async_pc", dut.pc, 32'h0);
    check("async_x1", dut.rf[1], 32'h0);
    dwait = 0;
    @(negedge CLK);
    release_check();
    run(600);
    check("rerun_x3", dut.rf[3], 32'hFFFF_FFFE);
    check("rerun_pc", dut.pc, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
